// File: rtl/motor_pkg.sv
// Shared types and constants for the H-bridge motor driver.
package motor_pkg;

    typedef enum logic [1:0] {
        RUN,
        RAMP_DOWN,
        DEAD
    } state_e;

    localparam logic [3:0] MAX_LEVEL = 4'd9;
    localparam logic       DIR_R     = 1'b1;
    localparam logic       DIR_L     = 1'b0;

    function automatic logic [3:0] clamp_level(input logic [3:0] v);
        return (v > MAX_LEVEL) ? MAX_LEVEL : v;
    endfunction

    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] goal);
        if (cur < goal) begin
            return cur + 4'd1;
        end else if (cur > goal) begin
            return cur - 4'd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// PWM generator: period of 9*STEP cycles, duty = level*STEP, new duty taken only at period start.
module pwm_gen
    import motor_pkg::*;
#(
    parameter int STEP = 556
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic [3:0] level,
    output logic       pwm
);
    localparam int PERIOD = int'(MAX_LEVEL) * STEP;
    localparam int CW     = $clog2(PERIOD + 1);

    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] duty_q;
    logic [CW-1:0] duty_now;
    logic          period_start;

    assign period_start = (pcnt_q == '0);
    assign duty_now     = CW'(level) * CW'(STEP);
    assign pcnt_d       = (pcnt_q == CW'(PERIOD - 1)) ? '0 : pcnt_q + CW'(1);

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            pcnt_q <= '0;
            duty_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            if (period_start) begin
                duty_q <= duty_now;
            end
        end
    end

    // The first cycle of a period already uses the freshly latched duty, so 0 and full scale never glitch.
    assign pwm = pcnt_q < (period_start ? duty_now : duty_q);

endmodule

// File: rtl/motor_pwm_driver.sv
// H-bridge driver: ramps duty toward the commanded speed and reverses via ramp-down and dead time.
// Define SOFT_RAMP_EN for one-level steps every RAMP_TICKS; otherwise the level jumps to its goal.
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int STEP       = 556,
    parameter int RAMP_TICKS = 5_000_000,
    parameter int DEAD_TICKS = 1_000_000
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic [3:0] speed,
    input  logic       turn,
    output logic       pwm_ena,
    output logic       in1,
    output logic       in2,
    output logic [3:0] level,
    output logic       busy
);
    localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

    state_e        state_q, state_d;
    logic          dir_q, dir_d;
    logic [3:0]    level_q, level_d;
    logic [3:0]    target_q;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          ramp_wrap;
    logic          pwm_raw;
    logic          coast;

    assign ramp_wrap = (rcnt_q == RW'(RAMP_TICKS - 1));

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            dir_q    <= DIR_R;
            level_q  <= '0;
            target_q <= '0;
            rcnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            level_q  <= level_d;
            target_q <= clamp_level(speed);
            rcnt_q   <= rcnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        level_d = level_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = ramp_wrap ? '0 : rcnt_q + RW'(1);
        case (state_q)
            RUN: begin
                if (turn != dir_q) begin
                    state_d = RAMP_DOWN;
                end else begin
`ifdef SOFT_RAMP_EN
                    if (ramp_wrap) begin
                        level_d = step_toward(level_q, target_q);
                    end
`else
                    level_d = target_q;
`endif
                end
            end
            RAMP_DOWN: begin
                // Turn restored before reaching zero: resume at the current level.
                if (turn == dir_q) begin
                    state_d = RUN;
`ifdef SOFT_RAMP_EN
                end else if (level_q == '0) begin
                    state_d = DEAD;
                    dcnt_d  = '0;
                    rcnt_d  = '0;
                end else if (ramp_wrap) begin
                    level_d = level_q - 4'd1;
                end
`else
                end else begin
                    state_d = DEAD;
                    level_d = '0;
                    dcnt_d  = '0;
                    rcnt_d  = '0;
                end
`endif
            end
            DEAD: begin
                rcnt_d = '0;
                if (dcnt_q == DW'(DEAD_TICKS - 1)) begin
                    dir_d   = turn;
                    state_d = RUN;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    pwm_gen #(
        .STEP(STEP)
    ) u_pwm (
        .clk100(clk100),
        .reset (reset),
        .level (level_q),
        .pwm   (pwm_raw)
    );

    // Reset forces coast combinationally so the bridge releases without waiting for a clock.
    assign coast   = reset | (state_q == DEAD);
    assign in1     = ~coast & dir_q;
    assign in2     = ~coast & ~dir_q;
    assign pwm_ena = ~coast & pwm_raw;
    assign level   = level_q;
    assign busy    = (state_q != RUN) | (level_q != target_q);

endmodule
